// File: rtl/stream_cipher_ctrl.sv
// stream_cipher_ctrl
//   Shares one W-bit XOR keystream stage between an encrypt requester
//   (channel 0) and a decrypt requester (channel 1). It holds a key per
//   channel, grants the stage to at most one channel per cycle
//   (round-robin on contention) and registers each XOR result into a
//   single-entry valid/ready output buffer.
//
// Optional feature (macro KEY_ROTATE_EN):
//   When defined, the key of the channel that just transferred rotates
//   left by one bit after every transfer. When undefined, keys stay
//   static between key_load events.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   key_load   in   load key_seed into both channel keys, flush buffer
//   key_seed   in   [W-1:0] key value
//   req0_*     encrypt channel  (valid/data in, ready out)
//   req1_*     decrypt channel  (valid/data in, ready out)
//   out_valid  out  output buffer holds a result
//   out_data   out  [W-1:0] XOR result
//   out_src    out  channel that produced out_data
//   out_ready  in   consumer accepts the result
//   keyed      out  a key has been loaded since reset
//   xfer_cnt   out  [CNT_W-1:0] results consumed, wrapping

module stream_cipher_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [W-1:0]     key_seed,
  input  logic             req0_valid,
  input  logic [W-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [W-1:0]     req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             keyed,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    UNKEYED = 1'b0,
    KEYED   = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   key0;
  logic [W-1:0]   key1;
  logic           last_grant;
  logic           space;
  logic           consume;
  logic           xfer0;
  logic           xfer1;

`ifdef KEY_ROTATE_EN
  function automatic logic [W-1:0] rotl1(input logic [W-1:0] k);
    return {k[W-2:0], k[W-1]};
  endfunction
`endif

  // The buffer can take a new result if it is empty or being drained now.
  assign consume = out_valid && out_ready;
  assign space   = !out_valid || out_ready;

  assign keyed = (state == KEYED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNKEYED;
    end else begin
      state <= state_nxt;
    end
  end

  // KEYED is sticky; only reset returns the block to UNKEYED.
  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = KEYED;
    end
  end

  // Grant logic: key_load blocks all grants for the cycle; on contention
  // the channel that did not win last time is served.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == KEYED && !key_load && space) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;

  // Keys, output buffer, arbitration history and consume counter.
  // A key_load overrides a same-cycle consume: the consumer still takes
  // the current data, but the counter clears instead of incrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key0       <= '0;
      key1       <= '0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      xfer_cnt   <= '0;
    end else if (key_load) begin
      key0      <= key_seed;
      key1      <= key_seed;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      if (consume) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (xfer0) begin
        out_data   <= req0_data ^ key0;
        out_src    <= 1'b0;
        out_valid  <= 1'b1;
        last_grant <= 1'b0;
`ifdef KEY_ROTATE_EN
        key0       <= rotl1(key0);
`endif
      end else if (xfer1) begin
        out_data   <= req1_data ^ key1;
        out_src    <= 1'b1;
        out_valid  <= 1'b1;
        last_grant <= 1'b1;
`ifdef KEY_ROTATE_EN
        key1       <= rotl1(key1);
`endif
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// tb_stream_cipher_ctrl
//   Self-checking bench for stream_cipher_ctrl (W=4, CNT_W=8). A
//   behavioural model of the controller (keys, buffer contents, consume
//   count, round-robin history) predicts every output each cycle.
//   Honours KEY_ROTATE_EN the same way as the design.

module tb_stream_cipher_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_load;
  logic [3:0] key_seed;
  logic       req0_valid;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic       keyed;
  logic [7:0] xfer_cnt;

  int compCount = 0;
  int failCount = 0;

  // Reference model state
  int mKey[2];
  int mLast;
  int mValid;
  int mData;
  int mSrc;
  int mCnt;
  int mKeyed;

  stream_cipher_ctrl #(.W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_seed   (key_seed),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .keyed      (keyed),
    .xfer_cnt   (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mKey[0] = 0;
    mKey[1] = 0;
    mLast   = 1;
    mValid  = 0;
    mData   = 0;
    mSrc    = 0;
    mCnt    = 0;
    mKeyed  = 0;
  endtask

  // Drives one cycle of inputs at the falling edge, checks every output
  // against the model, then advances the model across the rising edge.
  task automatic applyStimulus(input logic kl, input logic [3:0] seed,
                               input logic v0, input logic [3:0] d0,
                               input logic v1, input logic [3:0] d1,
                               input logic ordy);
    int winner;
    int dIn[2];
    @(negedge clk);
    key_load   = kl;
    key_seed   = seed;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    #1;
    dIn[0] = d0;
    dIn[1] = d1;
    // Winner this cycle: -1 for none.
    winner = -1;
    if (mKeyed == 1 && !kl && (mValid == 0 || ordy)) begin
      if (v0 && v1) winner = 1 - mLast;
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
    end
    checkOutput("req0_ready", req0_ready, (winner == 0) ? 1 : 0);
    checkOutput("req1_ready", req1_ready, (winner == 1) ? 1 : 0);
    checkOutput("out_valid",  out_valid,  mValid);
    checkOutput("keyed",      keyed,      mKeyed);
    checkOutput("xfer_cnt",   xfer_cnt,   mCnt);
    if (mValid == 1) begin
      checkOutput("out_data", out_data, mData);
      checkOutput("out_src",  out_src,  mSrc);
    end
    if (kl) begin
      mKey[0] = seed;
      mKey[1] = seed;
      mValid  = 0;
      mCnt    = 0;
      mKeyed  = 1;
    end else begin
      if (mValid == 1 && ordy) begin
        mCnt   = (mCnt + 1) % 256;
        mValid = 0;
      end
      if (winner >= 0) begin
        mData  = dIn[winner] ^ mKey[winner];
        mSrc   = winner;
        mValid = 1;
        mLast  = winner;
`ifdef KEY_ROTATE_EN
        mKey[winner] = ((mKey[winner] * 2) + (mKey[winner] / 8)) % 16;
`endif
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [3:0] expSecond;
`ifdef KEY_ROTATE_EN
    expSecond = 4'b0011;
`else
    expSecond = 4'b1100;
`endif
    rst_n      = 1'b0;
    key_load   = 1'b0;
    key_seed   = 4'h0;
    req0_valid = 1'b0;
    req0_data  = 4'h0;
    req1_valid = 1'b0;
    req1_data  = 4'h0;
    out_ready  = 1'b0;
    modelReset();
    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data",  out_data,  0);
    checkOutput("rst_out_src",   out_src,   0);
    checkOutput("rst_keyed",     keyed,     0);
    checkOutput("rst_xfer_cnt",  xfer_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unkeyed: requests are ignored
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 4'h5, 0, 0, 1);

    // Round-robin contention right after the first key_load
    applyStimulus(1, 4'b1010, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 4'h0, 1, 4'h0, 1);
      #1;
      checkOutput("rr_src", out_src, i % 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Encrypt example and key rotation behaviour
    applyStimulus(1, 4'b1010, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 4'b0110, 0, 0, 1);
    #1;
    checkOutput("ex_valid", out_valid, 1);
    checkOutput("ex_data",  out_data,  4'b1100);
    checkOutput("ex_src",   out_src,   0);
    applyStimulus(0, 0, 1, 4'b0110, 0, 0, 1);
    #1;
    checkOutput("ex_cnt",   xfer_cnt,  1);
    checkOutput("ex_data2", out_data,  expSecond);

    // Backpressure: result held, no grants
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 4'($urandom), 1, 4'($urandom), 0);
      #1;
      checkOutput("bp_data", out_data, expSecond);
    end
    applyStimulus(0, 0, 0, 0, 1, 4'h9, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Counter to 255 with a held result, then key_load with a consume
    applyStimulus(1, 4'($urandom), 0, 0, 0, 0, 1);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 1, 4'($urandom), 0, 0, 1);
    #1;
    checkOutput("pre_load_cnt",   xfer_cnt,  255);
    checkOutput("pre_load_valid", out_valid, 1);
    applyStimulus(1, 4'($urandom), 0, 0, 0, 0, 1);
    #1;
    checkOutput("load_clr_valid", out_valid, 0);
    checkOutput("load_clr_cnt",   xfer_cnt,  0);

    // 256 consumes from zero wrap the counter
    for (int i = 0; i < 257; i++) applyStimulus(0, 0, 1, 4'($urandom), 0, 0, 1);
    #1;
    checkOutput("wrap_cnt",   xfer_cnt,  0);
    checkOutput("wrap_valid", out_valid, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), 4'($urandom),
                    1'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of traffic takes effect without a clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_keyed", keyed,     0);
    checkOutput("midrst_cnt",   xfer_cnt,  0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'h3, 1, 4'h4, 1);
    applyStimulus(1, 4'h6, 0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 0, 1'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", compCount, failCount);
    $finish;
  end

endmodule
